io_wait_controller: RTL and testbench

//  Sequences the CPU's wait-for-switch instructions. While the control path holds waitReq,

---
 rtl/io_wait_controller_pkg.sv | 10 +
 rtl/io_wait_controller_sync2.sv | 31 +++
 rtl/io_wait_controller.sv | 96 +++++++++
 tb/tb_io_wait_controller.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/io_wait_controller_pkg.sv
// Shared types for the switch-wait sequencer.
package io_wait_controller_pkg;

    typedef enum logic [1:0] {
        IO_IDLE     = 2'd0,
        IO_DEBOUNCE = 2'd1,
        IO_DONE     = 2'd2
    } ioWaitState_t;

endpackage

// File: rtl/io_wait_controller_sync2.sv
// Two-flop synchroniser for asynchronous board inputs; clears to zero on reset.
module sync2 #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] stage1_q, stage1_d;
    logic [W-1:0] stage2_q, stage2_d;

    always_comb begin
        stage1_d = d;
        stage2_d = stage1_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stage1_q <= '0;
            stage2_q <= '0;
        end else begin
            stage1_q <= stage1_d;
            stage2_q <= stage2_d;
        end
    end

    assign q = stage2_q;

endmodule

// File: rtl/io_wait_controller.sv
// Stalls the CPU on a switch-wait instruction until the go switch has held the
// requested level for DEBOUNCE_CYCLES synchronised samples, then captures sw.
module io_wait_controller
    import io_wait_controller_pkg::*;
#(
    parameter int N               = 8,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         waitReq,
    input  logic         waitLevel,
    input  logic         swGo,
    input  logic [N-1:0] sw,
    output logic         stall,
    output logic [N-1:0] inData,
    output logic         inValid,
    output logic         busy
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] COUNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [N:0]   sync_q;
    logic         go_s;
    logic [N-1:0] sw_s;

    sync2 #(.W(N + 1)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   ({swGo, sw}),
        .q   (sync_q)
    );

    assign go_s = sync_q[N];
    assign sw_s = sync_q[N-1:0];

    ioWaitState_t  state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [N-1:0]  in_data_q, in_data_d;

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        in_data_d = in_data_q;
        case (state_q)
            IO_IDLE: begin
                count_d = '0;
                if (waitReq) begin
                    state_d = IO_DEBOUNCE;
                end
            end
            IO_DEBOUNCE: begin
                if (!waitReq) begin
                    state_d = IO_IDLE;
                    count_d = '0;
                end else if (go_s != waitLevel) begin
                    // Any mismatch, including a level change, forfeits all credit.
                    count_d = '0;
                end else if (count_q == COUNT_LAST) begin
                    in_data_d = sw_s;
                    state_d   = IO_DONE;
                    count_d   = '0;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end
            IO_DONE: begin
                state_d = IO_IDLE;
                count_d = '0;
            end
            default: begin
                state_d = IO_IDLE;
                count_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IO_IDLE;
            count_q   <= '0;
            in_data_q <= '0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            in_data_q <= in_data_d;
        end
    end

    assign stall   = waitReq && (state_q != IO_DONE);
    assign inValid = (state_q == IO_DONE);
    assign busy    = (state_q != IO_IDLE);
    assign inData  = in_data_q;

endmodule

// File: tb/tb_io_wait_controller.sv
// Self-checking bench for io_wait_controller: vector table, corner-case sequences
// and randomized traffic compared against a match-history reference model.
module tb_io_wait_controller;

    localparam int N = 8;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         waitReq = 1'b0;
    logic         waitLevel = 1'b0;
    logic         swGo = 1'b0;
    logic [N-1:0] sw = '0;
    logic         stall;
    logic [N-1:0] inData;
    logic         inValid;
    logic         busy;

    int total = 0;
    int bad   = 0;
    int pulses = 0;

    always #5 clk = ~clk;

    io_wait_controller #(.N(N), .DEBOUNCE_CYCLES(D)) dut (
        .clk       (clk),
        .rst       (rst),
        .waitReq   (waitReq),
        .waitLevel (waitLevel),
        .swGo      (swGo),
        .sw        (sw),
        .stall     (stall),
        .inData    (inData),
        .inValid   (inValid),
        .busy      (busy)
    );

    // Reference model: a wait is released once the last D synchronised samples
    // taken during the wait all matched the level requested at that sample.
    logic [N:0]   m_pipe0 = '0;
    logic [N:0]   m_pipe1 = '0;
    bit           m_active = 1'b0;
    bit           m_done = 1'b0;
    logic [N-1:0] m_data = '0;
    bit           m_hist[$];

    function automatic int trailing_matches();
        int cnt = 0;
        for (int i = m_hist.size() - 1; i >= 0; i--) begin
            if (!m_hist[i]) break;
            cnt++;
        end
        return cnt;
    endfunction

    task automatic model_step();
        logic         gos;
        logic [N-1:0] sws;
        if (rst) begin
            m_active = 1'b0;
            m_done   = 1'b0;
            m_data   = '0;
            m_pipe0  = '0;
            m_pipe1  = '0;
            m_hist.delete();
        end else begin
            gos = m_pipe1[N];
            sws = m_pipe1[N-1:0];
            if (m_done) begin
                m_done = 1'b0;
            end else if (!m_active) begin
                if (waitReq) begin
                    m_active = 1'b1;
                    m_hist.delete();
                end
            end else if (!waitReq) begin
                m_active = 1'b0;
                m_hist.delete();
            end else begin
                m_hist.push_back(gos == waitLevel);
                if (trailing_matches() >= D) begin
                    m_data   = sws;
                    m_done   = 1'b1;
                    m_active = 1'b0;
                    m_hist.delete();
                end
            end
            m_pipe1 = m_pipe0;
            m_pipe0 = {swGo, sw};
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One clock: model advances on the edge, outputs compared on the falling edge.
    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check("model_stall",   32'(stall),   32'(waitReq && !m_done));
        check("model_busy",    32'(busy),    32'(m_active || m_done));
        check("model_inValid", 32'(inValid), 32'(m_done));
        check("model_inData",  32'(inData),  32'(m_data));
        if (inValid) pulses++;
    endtask

    task automatic wait_valid(input int max_cycles, output int n);
        n = 0;
        do begin
            cycle();
            n++;
        end while (!inValid && n < max_cycles);
        check("wait_valid_timeout", 32'(inValid), 32'd1);
    endtask

    typedef struct {
        logic         rst;
        logic         wreq;
        logic         lvl;
        logic         go;
        logic [N-1:0] sw;
        logic         e_stall;
        logic         e_busy;
        logic         e_valid;
        logic [N-1:0] e_data;
    } vec_t;

    vec_t vecs[11];

    initial begin
        int n;
        int p0;
        int hit;
        bit bounce[9];

        // Reset, then a clean press with swGo first sampled high on row 3.
        vecs[0]  = '{1, 0, 1, 0, 8'hA5, 0, 0, 0, 8'h00};
        vecs[1]  = '{1, 0, 1, 0, 8'hA5, 0, 0, 0, 8'h00};
        vecs[2]  = '{0, 1, 1, 0, 8'hA5, 1, 1, 0, 8'h00};
        vecs[3]  = '{0, 1, 1, 1, 8'hA5, 1, 1, 0, 8'h00};
        vecs[4]  = '{0, 1, 1, 1, 8'hA5, 1, 1, 0, 8'h00};
        vecs[5]  = '{0, 1, 1, 1, 8'hA5, 1, 1, 0, 8'h00};
        vecs[6]  = '{0, 1, 1, 1, 8'hA5, 1, 1, 0, 8'h00};
        vecs[7]  = '{0, 1, 1, 1, 8'hA5, 1, 1, 0, 8'h00};
        vecs[8]  = '{0, 1, 1, 1, 8'hA5, 0, 1, 1, 8'hA5};
        vecs[9]  = '{0, 0, 1, 1, 8'hA5, 0, 0, 0, 8'hA5};
        vecs[10] = '{0, 0, 1, 0, 8'hA5, 0, 0, 0, 8'hA5};

        @(negedge clk);
        for (int i = 0; i < 11; i++) begin
            rst = vecs[i].rst; waitReq = vecs[i].wreq; waitLevel = vecs[i].lvl;
            swGo = vecs[i].go; sw = vecs[i].sw;
            cycle();
            check($sformatf("vec%0d_stall", i),   32'(stall),   32'(vecs[i].e_stall));
            check($sformatf("vec%0d_busy", i),    32'(busy),    32'(vecs[i].e_busy));
            check($sformatf("vec%0d_inValid", i), 32'(inValid), 32'(vecs[i].e_valid));
            check($sformatf("vec%0d_inData", i),  32'(inData),  32'(vecs[i].e_data));
            $display("vec %0d: rst=%0b wreq=%0b go=%0b -> stall=%0b busy=%0b valid=%0b data=%02h",
                     i, rst, waitReq, swGo, stall, busy, inValid, inData);
        end

        // Bounce: the 0 restarts the count; release after 4 matching samples of the last rise.
        bounce = '{1, 1, 0, 1, 1, 1, 1, 1, 1};
        waitLevel = 1'b1; swGo = 1'b0; sw = 8'h5A;
        for (int i = 0; i < 4; i++) cycle();
        waitReq = 1'b1;
        cycle();
        p0 = pulses; hit = -1;
        for (int i = 0; i < 9; i++) begin
            swGo = bounce[i];
            cycle();
            if (inValid && hit < 0) hit = i;
        end
        waitReq = 1'b0;
        cycle();
        check("bounce_pulses", 32'(pulses - p0), 32'd1);
        check("bounce_index", 32'(hit), 32'd8);
        check("bounce_data", 32'(inData), 32'h5A);
        $display("bounce: pulse at step %0d, data=%02h", hit, inData);

        // Release wait with the switch already settled low.
        waitLevel = 1'b0; swGo = 1'b0; sw = 8'h3C;
        for (int i = 0; i < 10; i++) cycle();
        waitReq = 1'b1;
        wait_valid(20, n);
        check("release_latency", 32'(n), 32'(D + 1));
        check("release_data", 32'(inData), 32'h3C);
        waitReq = 1'b0;
        cycle();
        $display("release: latency=%0d data=%02h", n, inData);

        // Abort after two matching cycles.
        waitLevel = 1'b1; swGo = 1'b1; sw = 8'hF0;
        for (int i = 0; i < 4; i++) cycle();
        p0 = pulses;
        waitReq = 1'b1;
        for (int i = 0; i < 3; i++) cycle();
        waitReq = 1'b0;
        cycle();
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_pulses", 32'(pulses - p0), 32'd0);
        check("abort_data", 32'(inData), 32'h3C);
        $display("abort: busy=%0b data=%02h", busy, inData);

        // Reset mid-debounce.
        waitReq = 1'b1;
        for (int i = 0; i < 3; i++) cycle();
        rst = 1'b1;
        cycle();
        check("rst_mid_data", 32'(inData), 32'h00);
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_stall", 32'(stall), 32'd1);
        rst = 1'b0; waitReq = 1'b0;
        for (int i = 0; i < 3; i++) cycle();
        $display("rst mid-wait: busy=%0b data=%02h", busy, inData);

        // Back-to-back: press wait then release wait with waitReq held throughout.
        waitLevel = 1'b1; swGo = 1'b1; sw = 8'h81;
        for (int i = 0; i < 3; i++) cycle();
        waitReq = 1'b1;
        wait_valid(20, n);
        check("b2b_first_data", 32'(inData), 32'h81);
        waitLevel = 1'b0; swGo = 1'b0; sw = 8'h18;
        wait_valid(20, n);
        check("b2b_gap_min", 32'(n >= D + 1), 32'd1);
        check("b2b_second_data", 32'(inData), 32'h18);
        waitReq = 1'b0;
        cycle();
        $display("back-to-back: gap=%0d data=%02h", n, inData);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 9) == 0) waitReq = ~waitReq;
            if ($urandom_range(0, 3) == 0) swGo = ~swGo;
            if ($urandom_range(0, 29) == 0) waitLevel = ~waitLevel;
            sw = N'($urandom);
            cycle();
        end
        rst = 1'b0;
        $display("random: %0d cycles, %0d pulses", 3000, pulses);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
